// File: rtl/picoctrl_sequencer.sv
// picoctrl_sequencer: PicoCtrl execution core. Fetches from a combinational
// 32x16 ROM at PC, decodes, and retires one instruction per clock.
//
// Control handshake: start/stop are single-cycle pulses sampled on the rising
// edge; there is no valid/ready pair. stop outranks start. start while
// running has no effect.
module picoctrl_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [3:0]        cond_in,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        out_reg0,
  output logic [7:0]        out_reg1,
  output logic [7:0]        out_reg2,
  output logic [7:0]        out_reg3,
  output logic              running,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [1:0] ACT_NOP   = 2'b00;
  localparam logic [1:0] ACT_WRITE = 2'b01;
  localparam logic [1:0] ACT_JUMP  = 2'b10;
  localparam logic [1:0] ACT_HALT  = 2'b11;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        sync1_q, sync2_q;
  logic [7:0]        regs_q [NUM_REGS];
  logic              wr_en;

  // Instruction fields
  logic       ins_always;
  logic [1:0] ins_cidx;
  logic       ins_expect;
  logic [1:0] ins_action;
  logic [1:0] ins_sel;
  logic [7:0] ins_data;
  logic       cond_true;

  assign ins_always = rom_data[15];
  assign ins_cidx   = rom_data[14:13];
  assign ins_expect = rom_data[12];
  assign ins_action = rom_data[11:10];
  assign ins_sel    = rom_data[9:8];
  assign ins_data   = rom_data[7:0];
  assign cond_true  = ins_always | (sync2_q[ins_cidx] == ins_expect);

  // Two-flop synchronizer for the asynchronous condition inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= cond_in;
      sync2_q <= sync1_q;
    end
  end

  // State and program counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state, next-PC and write-enable decode
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (start && !stop) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end else if (cond_true) begin
          case (ins_action)
            ACT_WRITE: begin
              wr_en = 1'b1;
              pc_d  = pc_q + PC_ONE;
            end
            ACT_JUMP: pc_d = ins_data[ADDR_W-1:0];
            ACT_HALT: state_d = S_HALT;
            ACT_NOP:  pc_d = pc_q + PC_ONE;
            default:  pc_d = pc_q + PC_ONE;
          endcase
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end
      S_HALT: begin
        if (stop) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end else if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // Output register file; written only by a taken write instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[ins_sel] <= ins_data;
    end
  end

  assign rom_addr = pc_q;
  assign out_reg0 = regs_q[0];
  assign out_reg1 = regs_q[1];
  assign out_reg2 = regs_q[2];
  assign out_reg3 = regs_q[3];
  assign running  = (state_q == S_RUN);
  assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_picoctrl_sequencer.sv
// tb_picoctrl_sequencer: directed phases plus random programs for the PicoCtrl
// sequencer, checked cycle by cycle against an instruction-level model.
module tb_picoctrl_sequencer;

  localparam int W = 39;  // {pc[4:0], running, halted, r3, r2, r1, r0}

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [3:0]  cond_in;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data;
  logic [7:0]  out_reg0, out_reg1, out_reg2, out_reg3;
  logic        running;
  logic        halted;

  logic [15:0] rom [32];
  assign rom_data = rom[rom_addr];

  picoctrl_sequencer #(.ADDR_W(5), .NUM_REGS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .cond_in  (cond_in),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .out_reg0 (out_reg0),
    .out_reg1 (out_reg1),
    .out_reg2 (out_reg2),
    .out_reg3 (out_reg3),
    .running  (running),
    .halted   (halted)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 running, 2 halted
  int         m_mode;
  int         m_pc;
  logic [7:0] m_reg [4];
  logic [3:0] cond_hist[$];  // cond_in values sampled at the last two edges
  logic       p_start, p_stop;
  logic [3:0] p_cond;

  function automatic logic [15:0] ins(input bit al, input int ci, input bit v,
                                      input int act, input int sel, input int data);
    logic [15:0] r;
    r = {al, 2'(ci), v, 2'(act), 2'(sel), 8'(data)};
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 0;
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    cond_hist = {4'h0, 4'h0};
  endtask

  // One clock edge: inputs applied during the previous cycle take effect.
  task automatic model_edge();
    logic [15:0] w;
    logic [3:0]  cs;
    bit          taken;
    int          act;
    cs = cond_hist.pop_front();
    cond_hist.push_back(p_cond);
    w = rom[m_pc];
    if (m_mode == 1) begin
      if (p_stop) begin
        m_mode = 0;
        m_pc   = 0;
      end else begin
        taken = (w[15] == 1'b1) || (cs[w[14:13]] == w[12]);
        act   = int'(w[11:10]);
        if (!taken || act == 0) m_pc = (m_pc + 1) % 32;
        else if (act == 1) begin
          m_reg[w[9:8]] = w[7:0];
          m_pc = (m_pc + 1) % 32;
        end else if (act == 2) m_pc = int'(w[7:0]) % 32;
        else m_mode = 2;
      end
    end else if (m_mode == 2) begin
      if (p_stop) begin
        m_mode = 0;
        m_pc   = 0;
      end else if (p_start) begin
        m_mode = 1;
        m_pc   = 0;
      end
    end else begin
      m_pc = 0;
      if (p_start && !p_stop) m_mode = 1;
    end
  endtask

  function automatic logic [W-1:0] model_pack();
    return {5'(m_pc), (m_mode == 1), (m_mode == 2), m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic st, input logic sp, input logic [3:0] c, input logic rn);
    @(posedge clk);
    #1;
    if (rst_n) model_edge();
    rst_n = rn;
    if (!rn) model_reset();
    start   = st;
    stop    = sp;
    cond_in = c;
    p_start = st;
    p_stop  = sp;
    p_cond  = c;
    exp_q.push_back(model_pack());
  endtask

  task automatic idle_cycles(input int n, input logic [3:0] c);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, c, 1'b1);
  endtask

  task automatic rom_fill(input logic [15:0] w);
    for (int i = 0; i < 32; i++) rom[i] = w;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {rom_addr, running, halted, out_reg3, out_reg2, out_reg1, out_reg0};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_state t=%0t: got pc=%0d run=%b halt=%b r=%h_%h_%h_%h, expected pc=%0d run=%b halt=%b r=%h_%h_%h_%h",
                 $time, a[38:34], a[33], a[32], a[31:24], a[23:16], a[15:8], a[7:0],
                 e[38:34], e[33], e[32], e[31:24], e[23:16], e[15:8], e[7:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    cond_in = 4'h0;
    p_start = 1'b0;
    p_stop  = 1'b0;
    p_cond  = 4'h0;
    rom_fill(16'h0000);
    model_reset();

    cycle(1'b0, 1'b0, 4'h0, 1'b0);
    cycle(1'b0, 1'b0, 4'h0, 1'b0);
    idle_cycles(3, 4'h0);

    // Reset mid-run, then stay idle with start low
    rom[0] = ins(1, 0, 0, 1, 3, 8'h77);
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    idle_cycles(5, 4'h0);
    cycle(1'b0, 1'b0, 4'h0, 1'b0);
    cycle(1'b0, 1'b0, 4'h0, 1'b0);
    idle_cycles(10, 4'h0);
    check("reset_out_reg3", int'(out_reg3), 0);
    check("reset_running", int'(running), 0);

    // Unconditional write sequence
    rom_fill(16'h0000);
    rom[0] = ins(1, 0, 0, 1, 0, 8'h01);
    rom[1] = ins(1, 0, 0, 1, 2, 8'hA5);
    rom[2] = ins(1, 0, 0, 3, 0, 0);
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    idle_cycles(6, 4'h0);
    check("write_out_reg0", int'(out_reg0), 8'h01);
    check("write_out_reg2", int'(out_reg2), 8'hA5);
    check("write_halted", int'(halted), 1);
    check("write_pc_hold", int'(rom_addr), 2);

    // Poll loop on c1 through the synchronizer
    rom_fill(16'h0000);
    rom[0] = ins(1, 0, 0, 2, 0, 5);
    rom[5] = ins(0, 1, 1, 2, 0, 5);
    rom[6] = ins(1, 0, 0, 3, 0, 0);
    cycle(1'b0, 1'b1, 4'h2, 1'b1);
    idle_cycles(3, 4'h2);
    cycle(1'b1, 1'b0, 4'h2, 1'b1);
    idle_cycles(8, 4'h2);
    idle_cycles(6, 4'h0);
    check("poll_exit_pc", int'(rom_addr), 6);
    check("poll_halted", int'(halted), 1);

    // Wrap-around with all nops
    rom_fill(16'h0000);
    cycle(1'b0, 1'b1, 4'h0, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    idle_cycles(40, 4'h0);
    check("wrap_running", int'(running), 1);
    check("wrap_not_halted", int'(halted), 0);

    // Jump target truncated to the address width
    rom[0] = ins(1, 0, 0, 2, 0, 8'hE3);
    rom[3] = ins(1, 0, 0, 3, 0, 0);
    cycle(1'b0, 1'b1, 4'h0, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    idle_cycles(4, 4'h0);
    check("jump_trunc_pc", int'(rom_addr), 3);

    // start+stop together while running: stop wins
    rom_fill(16'h0000);
    rom[0] = ins(1, 0, 0, 1, 1, 8'h3C);
    cycle(1'b0, 1'b1, 4'h0, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    idle_cycles(5, 4'h0);
    cycle(1'b1, 1'b1, 4'h0, 1'b1);
    idle_cycles(2, 4'h0);
    check("prio_running", int'(running), 0);
    check("prio_pc", int'(rom_addr), 0);
    check("prio_out_reg1", int'(out_reg1), 8'h3C);
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    idle_cycles(3, 4'h0);
    check("prio_resume", int'(running), 1);

    // Random programs, conditions and control pulses
    for (int blk = 0; blk < 10; blk++) begin
      logic [3:0] c;
      c = 4'($urandom_range(0, 15));
      for (int i = 0; i < 32; i++) rom[i] = 16'($urandom_range(0, 65535));
      for (int n = 0; n < 200; n++) begin
        logic st, sp, rn;
        if ($urandom_range(0, 3) == 0) c = 4'($urandom_range(0, 15));
        st = ($urandom_range(0, 9) == 0);
        sp = ($urandom_range(0, 29) == 0);
        rn = ($urandom_range(0, 149) != 0);
        cycle(st, sp, c, rn);
      end
    end

    idle_cycles(2, 4'h0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/picoctrl_sequencer.md
# picoctrl_sequencer

Execution core for the PicoCtrl micro-controller. It drives the address of the 32-entry, 16-bit combinational instruction ROM, decodes the returned word, and evaluates one instruction per clock. It tests synchronized condition inputs and updates four 8-bit output registers or the program counter. It sits between the program ROM and the board-level outputs (LED bars, enables) and is started and stopped by the top level.

## Interface
- ADDR_W, 5, ROM address width; the PC is ADDR_W bits.
- NUM_REGS, 4, output registers; fixed at 4 by the 2-bit register field.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; IDLE/HALT -> RUN from PC 0.
- stop  in  1  one-cycle pulse; RUN -> IDLE; priority over start.
- cond_in  in  4  asynchronous condition inputs c0..c3.
- rom_addr  out  ADDR_W  equals PC; the ROM returns rom_data in the same cycle.
- rom_data  in  16  instruction word.
- out_reg0..out_reg3  out  8 each  registered output registers.
- running  out  1  high in RUN.
- halted  out  1  high in HALT.

## Operation
- Instruction fields:
  - [15] always: 1 = unconditional.
  - [14:13] cond index i.
  - [12] expected value v.
  - [11:10] action: 00 nop, 01 write, 10 jump, 11 halt.
  - [9:8] register select.
  - [7:0] data.
- Condition true when [15]=1 or cs[i]==v. cs is cond_in after a 2-flop synchronizer.
- States are IDLE, RUN and HALT; reset enters IDLE.
- IDLE:
  - PC held at 0; no instruction executes.
  - start -> RUN.
- RUN, each cycle, instruction at PC:
  - condition false, nop, or reserved: PC <= PC+1.
  - write, condition true: out_reg[sel] <= data; PC <= PC+1.
  - jump, condition true: PC <= data[ADDR_W-1:0]; upper data bits ignored.
  - halt, condition true: -> HALT; PC unchanged.
- HALT:
  - outputs frozen.
  - start -> RUN with PC <= 0.
- stop in RUN or HALT -> IDLE with PC <= 0. Output registers keep their values.
- PC increment wraps 2^ADDR_W-1 -> 0.
- A jump to its own address is a poll loop: it re-evaluates every cycle until the condition goes false.

## Timing
- Reset values:
  - PC = 0, state IDLE, running = 0, halted = 0.
  - out_reg0..3 = 8'h00.
  - synchronizer flops = 0.
- Throughput is one instruction per cycle, with no stall or fetch bubble.
- A write is visible on out_regN on the cycle after the instruction is at PC.
- cond_in to usable condition: 2 clk. A level change on cond_in at edge k is tested by the instruction evaluated in cycle k+2.
- start sampled at edge k: running = 1 after edge k, and the instruction at PC 0 executes in cycle k+1.
- stop and start in the same cycle: stop wins and the state goes to IDLE.
- start while in RUN is ignored.
- rst_n asserted mid-instruction clears all state immediately, without waiting for the clock. After deassertion the block stays in IDLE until start.
- rom_addr changes only on clk edges, with no combinational path from rom_data.

## Test plan
- Reset/idle:
  - Stimulus: assert rst_n low mid-RUN, then release with start held low for 10 cycles.
  - Expected: out_reg0..3 = 0, rom_addr = 0, running = 0 throughout.
- Unconditional write sequence:
  - Stimulus: ROM 0: write r0=8'h01, 1: write r2=8'hA5, 2: halt; pulse start.
  - Expected: out_reg0 = 01 one cycle after start, then out_reg2 = A5, halted = 1 by cycle 3, PC stays 2.
- Poll loop with synchronizer latency:
  - Stimulus: instruction at 5 = jump-to-5 if c1==1; c1 = 1, then drop c1 at edge k.
  - Expected: PC holds 5 through cycle k+1 and reaches 6 in cycle k+3.
- Wrap-around:
  - Stimulus: ROM all nop except 31 = nop; run 40 cycles.
  - Expected: rom_addr goes 31 -> 0, with no halt.
- Jump field truncation:
  - Stimulus: jump data 8'hE3 with ADDR_W = 5.
  - Expected: PC = 3.
- Control priority:
  - Stimulus: start and stop asserted together while in RUN.
  - Expected: IDLE, PC = 0, out_regs keep their values. A later start alone resumes from PC 0.
